// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: waits for stable PLL lock, releases core then peripheral resets, re-sequences on loss or soft request
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int LOSS_FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_count
);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);
  localparam int FW = $clog2(LOSS_FILTER_CYCLES + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, REL_CORE, RUN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] loss_q, loss_d;
  logic [7:0] cnt_d;
  logic locked_s, filt_loss;
  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign filt_loss = (state_q == RUN) && (loss_q == FW'(LOSS_FILTER_CYCLES));
  // state, counters, synchroniser and registered resets; resets follow the next state so they change on the deciding edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q          <= '0;
      state_q         <= WAIT_LOCK;
      stab_q          <= '0;
      gap_q           <= '0;
      loss_q          <= '0;
      lock_loss_count <= '0;
      core_rst_n      <= 1'b0;
      periph_rst_n    <= 1'b0;
      ready           <= 1'b0;
    end else begin
      sync_q          <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q         <= state_d;
      stab_q          <= stab_d;
      gap_q           <= gap_d;
      loss_q          <= loss_d;
      lock_loss_count <= cnt_d;
      core_rst_n      <= (state_d == REL_CORE) || (state_d == RUN);
      periph_rst_n    <= state_d == RUN;
      ready           <= state_d == RUN;
    end
  end
  // next-state and counter logic; a filtered loss is counted even when a soft request arrives on the same edge
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    loss_d  = loss_q;
    cnt_d   = (filt_loss && lock_loss_count != 8'hFF) ? lock_loss_count + 8'd1 : lock_loss_count;
    if (soft_rst_req || filt_loss) begin
      state_d = WAIT_LOCK;
      stab_d  = '0;
      gap_d   = '0;
      loss_d  = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = locked_s ? STABLE : WAIT_LOCK;
          stab_d  = locked_s ? SW'(1) : '0;
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            stab_d  = '0;
          end else if (stab_q == SW'(LOCK_STABLE_CYCLES)) begin
            state_d = REL_CORE;
            stab_d  = '0;
            gap_d   = GW'(1);
          end else stab_d = stab_q + SW'(1);
        end
        REL_CORE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            gap_d   = '0;
          end else if (gap_q == GW'(STAGE_GAP_CYCLES)) begin
            state_d = RUN;
            gap_d   = '0;
            loss_d  = '0;
          end else gap_d = gap_q + GW'(1);
        end
        RUN: loss_d = locked_s ? '0 : loss_q + FW'(1);
        default: state_d = WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bring-up, glitch, loss, soft-request, async-reset and saturation checks via an expectation queue
module tb_pll_reset_sequencer;
  logic clk = 0, rst_n = 1, pll_locked = 0, soft_rst_req = 0;
  logic core_rst_n, periph_rst_n, ready;
  logic [7:0] lock_loss_count;
  int checks = 0, failures = 0, ecyc = -1;
  typedef struct {int cyc; logic [10:0] exp; string tag;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .STAGE_GAP_CYCLES(4), .LOSS_FILTER_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .core_rst_n(core_rst_n), .periph_rst_n(periph_rst_n), .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  function automatic logic [10:0] outs();
    return {core_rst_n, periph_rst_n, ready, lock_loss_count};
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s core/periph/ready=%b count=%0d, expected core/periph/ready=%b count=%0d",
             tag, obs[10:8], obs[7:0], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic expect_at(input int c, input logic co, input logic pe, input logic rd, input int n, input string tag);
    sb.push_back(exp_t'{c, {co, pe, rd, 8'(n)}, tag});
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    ecyc++;
    checks++;
    assert (!(periph_rst_n && !core_rst_n)) else begin
      failures++;
      $error("FAIL invariant cycle %0d periph_rst_n=%b core_rst_n=%b, expected periph_rst_n=0 while core held", ecyc, periph_rst_n, core_rst_n);
    end
    while (sb.size() > 0 && sb[0].cyc <= ecyc) begin
      e = sb.pop_front();
      if (e.cyc == ecyc) check(e.tag, outs(), e.exp);
      else begin
        checks++;
        failures++;
        $error("FAIL %s_missed at cycle %0d, expected at cycle %0d", e.tag, ecyc, e.cyc);
      end
    end
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic lk);
    rst_n = 0;
    soft_rst_req = 0;
    pll_locked = lk;
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1;
    ecyc = -1;
  endtask

  initial begin
    int n, c;
    #2 rst_n = 0;
    #1 check("reset_state", outs(), 11'd0);
    // clean bring-up
    do_reset(1);
    expect_at(0, 0, 0, 0, 0, "bringup_c0");
    expect_at(9, 0, 0, 0, 0, "bringup_pre_core");
    expect_at(10, 1, 0, 0, 0, "bringup_core");
    expect_at(13, 1, 0, 0, 0, "bringup_pre_periph");
    expect_at(14, 1, 1, 1, 0, "bringup_periph");
    stepn(21);
    // 2-cycle glitch is filtered out
    pll_locked = 0;
    expect_at(26, 1, 1, 1, 0, "glitch2_ignored");
    stepn(2);
    pll_locked = 1;
    stepn(8);
    // 3-cycle drop is a real loss
    pll_locked = 0;
    expect_at(35, 1, 1, 1, 0, "loss3_pre");
    expect_at(36, 0, 0, 0, 1, "loss3_reset");
    expect_at(44, 0, 0, 0, 1, "loss3_pre_core");
    expect_at(45, 1, 0, 0, 1, "loss3_core");
    expect_at(48, 1, 0, 0, 1, "loss3_pre_periph");
    expect_at(49, 1, 1, 1, 1, "loss3_run");
    stepn(3);
    pll_locked = 1;
    stepn(22);
    // soft request in RUN with lock held
    soft_rst_req = 1;
    expect_at(56, 0, 0, 0, 1, "soft_reset");
    expect_at(64, 0, 0, 0, 1, "soft_pre_core");
    expect_at(65, 1, 0, 0, 1, "soft_core");
    expect_at(68, 1, 0, 0, 1, "soft_pre_periph");
    expect_at(69, 1, 1, 1, 1, "soft_run");
    stepn(1);
    soft_rst_req = 0;
    stepn(19);
    // soft request on the same edge as a filtered loss
    pll_locked = 0;
    expect_at(80, 1, 1, 1, 1, "coinc_pre");
    expect_at(81, 0, 0, 0, 2, "coinc_counted_once");
    stepn(5);
    soft_rst_req = 1;
    stepn(1);
    soft_rst_req = 0;
    pll_locked = 1;
    expect_at(91, 0, 0, 0, 2, "coinc_pre_core");
    expect_at(92, 1, 0, 0, 2, "coinc_core");
    expect_at(94, 1, 0, 0, 2, "relcore_before_rst");
    stepn(13);
    // asynchronous reset mid REL_CORE, off the clock edge
    #3 rst_n = 0;
    #1 check("async_rst_immediate", outs(), 11'd0);
    do_reset(1);
    expect_at(0, 0, 0, 0, 0, "post_rst_c0");
    expect_at(10, 1, 0, 0, 0, "post_rst_core");
    expect_at(14, 1, 1, 1, 0, "post_rst_run");
    stepn(21);
    // unstable lock restarts the stability count
    do_reset(1);
    expect_at(10, 0, 0, 0, 0, "unstable_no_early");
    expect_at(15, 0, 0, 0, 0, "unstable_pre_core");
    expect_at(16, 1, 0, 0, 0, "unstable_core");
    expect_at(20, 1, 1, 1, 0, "unstable_run");
    stepn(5);
    pll_locked = 0;
    stepn(1);
    pll_locked = 1;
    stepn(15);
    // saturation of the loss counter
    for (int k = 1; k <= 260; k++) begin
      c = ecyc;
      n = (k > 255) ? 255 : k;
      pll_locked = 0;
      expect_at(c + 6, 0, 0, 0, n, $sformatf("sat_loss%0d", k));
      expect_at(c + 20, 1, 1, 1, n, $sformatf("sat_run%0d", k));
      stepn(5);
      pll_locked = 1;
      stepn(15);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_leftover pending=%0d, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
